// File: rtl/alu_share_arb.sv
// alu_share_arb: arbitrates two requesters onto one shared 32-bit combinational ALU.
// Latency: handshake at edge k, result captured at edge k+1; minimum 3 cycles per op.
// Backpressure: one op in flight; both req ready low until the owner's rsp handshake.
// Optional: define ALU_ARB_RR_EN for round-robin tie-breaking (default: fixed priority, req0 wins).
module alu_share_arb #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // requester 0
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [2:0]        req0_ctl_i,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  // requester 1
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [2:0]        req1_ctl_i,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  // responses
  output logic              rsp0_valid_o,
  input  logic              rsp0_ready_i,
  output logic              rsp1_valid_o,
  input  logic              rsp1_ready_i,
  output logic [DATA_W-1:0] rsp_result_o,
  output logic              rsp_zero_o,
  // shared ALU
  output logic [2:0]        alu_ctl_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  input  logic [DATA_W-1:0] alu_out_i,
  input  logic              alu_zero_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q;
  logic              owner_q;
  logic [2:0]        alu_ctl_q;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic              rsp_zero_q;
  logic              rsp0_valid_q;
  logic              rsp1_valid_q;

`ifdef ALU_ARB_RR_EN
  // Requester granted most recently; the other one wins the next tie.
  logic              last_q;
`endif

  logic              grant_vld;
  logic              grant_id;
  logic              rsp_hs;

  // Pick a winner among the valid requesters; a lone requester always wins.
  always_comb begin
    grant_vld = req0_valid_i | req1_valid_i;
    grant_id  = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
`ifdef ALU_ARB_RR_EN
      grant_id = ~last_q;
`else
      grant_id = 1'b0;
`endif
    end else if (req1_valid_i) begin
      grant_id = 1'b1;
    end
  end

  assign req0_ready_o = (state_q == IDLE) & grant_vld & ~grant_id;
  assign req1_ready_o = (state_q == IDLE) & grant_vld &  grant_id;

  // Response completes when the owner of the in-flight op takes it.
  assign rsp_hs = (state_q == RESP) & (owner_q ? rsp1_ready_i : rsp0_ready_i);

  // Sequencer: latch the granted op, drive the ALU for one cycle, hold the result until taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      alu_ctl_q    <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_q       <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            alu_ctl_q <= grant_id ? req1_ctl_i : req0_ctl_i;
            alu_a_q   <= grant_id ? req1_a_i   : req0_a_i;
            alu_b_q   <= grant_id ? req1_b_i   : req0_b_i;
            owner_q   <= grant_id;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= alu_out_i;
          rsp_zero_q   <= alu_zero_i;
          rsp0_valid_q <= ~owner_q;
          rsp1_valid_q <=  owner_q;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            state_q      <= IDLE;
`ifdef ALU_ARB_RR_EN
            last_q       <= owner_q;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign alu_ctl_o    = alu_ctl_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_zero_o   = rsp_zero_q;
  assign rsp0_valid_o = rsp0_valid_q;
  assign rsp1_valid_o = rsp1_valid_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed vector table, multi-cycle corner sequences and a
// randomized run checked against a transaction-level model of the arbiter.
// A behavioural ALU is attached to the DUT's ALU port.
module tb_alu_share_arb;

  logic        clk_i;
  logic        rst_ni;
  logic        rv [2];
  logic [2:0]  rc [2];
  logic [31:0] ra [2];
  logic [31:0] rb [2];
  logic        rr [2];
  logic        req0_ready_o, req1_ready_o;
  logic        rsp0_valid_o, rsp1_valid_o;
  logic [31:0] rsp_result_o;
  logic        rsp_zero_o;
  logic [2:0]  alu_ctl_o;
  logic [31:0] alu_a_o, alu_b_o;
  logic [31:0] alu_out_i;
  logic        alu_zero_i;

  int n_chk  = 0;
  int n_fail = 0;

  alu_share_arb #(.DATA_W(32)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req0_valid_i (rv[0]),
    .req0_ready_o (req0_ready_o),
    .req0_ctl_i   (rc[0]),
    .req0_a_i     (ra[0]),
    .req0_b_i     (rb[0]),
    .req1_valid_i (rv[1]),
    .req1_ready_o (req1_ready_o),
    .req1_ctl_i   (rc[1]),
    .req1_a_i     (ra[1]),
    .req1_b_i     (rb[1]),
    .rsp0_valid_o (rsp0_valid_o),
    .rsp0_ready_i (rr[0]),
    .rsp1_valid_o (rsp1_valid_o),
    .rsp1_ready_i (rr[1]),
    .rsp_result_o (rsp_result_o),
    .rsp_zero_o   (rsp_zero_o),
    .alu_ctl_o    (alu_ctl_o),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_out_i    (alu_out_i),
    .alu_zero_i   (alu_zero_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Behavioural ALU: {zero, result}
  function automatic logic [32:0] alu_f(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (c)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a + b;
      3'b110:  r = a - b;
      3'b111:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  assign {alu_zero_i, alu_out_i} = alu_f(alu_ctl_o, alu_a_o, alu_b_o);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input int id);
    return (id == 1) ? req1_ready_o : req0_ready_o;
  endfunction

  function automatic logic rspv(input int id);
    return (id == 1) ? rsp1_valid_o : rsp0_valid_o;
  endfunction

  task automatic do_reset();
    rst_ni = 1'b0;
    rv[0] = 1'b0; rv[1] = 1'b0;
    rr[0] = 1'b1; rr[1] = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // One complete transaction on requester id with rsp_ready held high.
  task automatic run_op(input int id, input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eres, input logic ez, input string nm);
    int n;
    n = 0;
    @(negedge clk_i);
    rv[id] = 1'b1; rc[id] = ctl; ra[id] = a; rb[id] = b;
    #1;
    while (!rdy(id) && n < 10) begin
      @(negedge clk_i); #1; n++;
    end
    chk({nm, "_ready"}, 32'(rdy(id)), 32'd1);
    @(negedge clk_i);
    rv[id] = 1'b0;
    #1;
    chk({nm, "_exec_ctl"}, 32'(alu_ctl_o), 32'(ctl));
    chk({nm, "_exec_a"}, alu_a_o, a);
    chk({nm, "_exec_b"}, alu_b_o, b);
    chk({nm, "_exec_norsp"}, 32'({rsp1_valid_o, rsp0_valid_o}), 32'd0);
    @(negedge clk_i); #1;
    chk({nm, "_rsp_valid"}, 32'(rspv(id)), 32'd1);
    chk({nm, "_rsp_other"}, 32'(rspv(1 - id)), 32'd0);
    chk({nm, "_result"}, rsp_result_o, eres);
    chk({nm, "_zero"}, 32'(rsp_zero_o), 32'(ez));
    @(negedge clk_i); #1;
    chk({nm, "_rsp_done"}, 32'(rspv(id)), 32'd0);
  endtask

  typedef struct {
    int          id;
    logic [2:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int       grants [$];
    int       n, n1rdy, exp_g;
    logic     m_busy, m_age, m_id, m_last;
    logic [2:0]  m_ctl;
    logic [31:0] m_a, m_b, m_res;
    logic        m_zero;
    logic        taken [2];
    int          w;
    logic [32:0] rz;

    vecs[0] = '{0, 3'b010, 32'd5,        32'd7,        32'd12,       1'b0};
    vecs[1] = '{1, 3'b110, 32'h1234,     32'h1234,     32'd0,        1'b1};
    vecs[2] = '{0, 3'b111, 32'd3,        32'd9,        32'd1,        1'b0};
    vecs[3] = '{1, 3'b011, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
    vecs[4] = '{0, 3'b000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0};
    vecs[5] = '{1, 3'b001, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0};
    vecs[6] = '{0, 3'b010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
    vecs[7] = '{1, 3'b111, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
    vecs[8] = '{0, 3'b100, 32'd77,       32'd88,       32'd0,        1'b1};

    for (int r = 0; r < 2; r++) begin
      rv[r] = 1'b0; rc[r] = 3'd0; ra[r] = 32'd0; rb[r] = 32'd0; rr[r] = 1'b1;
    end
    rst_ni = 1'b0;
    #1;
    // Reset state
    chk("rst_alu_ctl", 32'(alu_ctl_o), 32'd0);
    chk("rst_alu_a", alu_a_o, 32'd0);
    chk("rst_alu_b", alu_b_o, 32'd0);
    chk("rst_result", rsp_result_o, 32'd0);
    chk("rst_zero", 32'(rsp_zero_o), 32'd0);
    chk("rst_rspv", 32'({rsp1_valid_o, rsp0_valid_o}), 32'd0);
    do_reset();

    // Directed vector table
    for (int i = 0; i < 9; i++)
      run_op(vecs[i].id, vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].z, $sformatf("vec%0d", i));

    // Tie: both valid continuously for four grants
    do_reset();
    @(negedge clk_i);
    rv[0] = 1'b1; rc[0] = 3'b010; ra[0] = 32'd1; rb[0] = 32'd1;
    rv[1] = 1'b1; rc[1] = 3'b010; ra[1] = 32'd2; rb[1] = 32'd2;
    n = 0; n1rdy = 0;
    grants.delete();
    while (grants.size() < 4 && n < 40) begin
      #1;
      if (req0_ready_o) grants.push_back(0);
      if (req1_ready_o) begin grants.push_back(1); n1rdy++; end
      @(negedge clk_i);
      n++;
    end
    chk("tie_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
      exp_g = i % 2;
`else
      exp_g = 0;
`endif
      chk($sformatf("tie_grant%0d", i), (i < grants.size()) ? 32'(grants[i]) : 32'hFFFFFFFF, 32'(exp_g));
    end
`ifndef ALU_ARB_RR_EN
    chk("tie_req1_never_ready", 32'(n1rdy), 32'd0);
`endif
    rv[0] = 1'b0; rv[1] = 1'b0;

    // Backpressure: rsp0_ready low for 5 cycles while req1 waits
    do_reset();
    @(negedge clk_i);
    rr[0] = 1'b0;
    rv[0] = 1'b1; rc[0] = 3'b010; ra[0] = 32'd5; rb[0] = 32'd7;
    #1;
    chk("bp_req0_ready", 32'(req0_ready_o), 32'd1);
    @(negedge clk_i);
    rv[0] = 1'b0;
    @(negedge clk_i);
    rv[1] = 1'b1; rc[1] = 3'b010; ra[1] = 32'd1; rb[1] = 32'd2;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_rsp0_valid%0d", i), 32'(rsp0_valid_o), 32'd1);
      chk($sformatf("bp_result%0d", i), rsp_result_o, 32'd12);
      chk($sformatf("bp_req1_blocked%0d", i), 32'(req1_ready_o), 32'd0);
      if (i < 4) @(negedge clk_i);
    end
    rr[0] = 1'b1;
    @(negedge clk_i); #1;
    chk("bp_rsp0_done", 32'(rsp0_valid_o), 32'd0);
    chk("bp_req1_granted", 32'(req1_ready_o), 32'd1);
    @(negedge clk_i);
    rv[1] = 1'b0;
    @(negedge clk_i); #1;
    chk("bp_rsp1_valid", 32'(rsp1_valid_o), 32'd1);
    chk("bp_rsp1_result", rsp_result_o, 32'd3);
    @(negedge clk_i);

    // Reset during EXEC discards the op; pending req1 then completes
    @(negedge clk_i);
    rv[0] = 1'b1; rc[0] = 3'b110; ra[0] = 32'd50; rb[0] = 32'd8;
    #1;
    chk("mid_req0_ready", 32'(req0_ready_o), 32'd1);
    @(negedge clk_i);
    rv[0] = 1'b0;
    rv[1] = 1'b1; rc[1] = 3'b010; ra[1] = 32'd100; rb[1] = 32'd23;
    #1;
    chk("mid_exec_ctl", 32'(alu_ctl_o), 32'd6);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_alu_ctl", 32'(alu_ctl_o), 32'd0);
    chk("mid_rst_alu_a", alu_a_o, 32'd0);
    chk("mid_rst_alu_b", alu_b_o, 32'd0);
    chk("mid_rst_result", rsp_result_o, 32'd0);
    chk("mid_rst_zero", 32'(rsp_zero_o), 32'd0);
    chk("mid_rst_rspv", 32'({rsp1_valid_o, rsp0_valid_o}), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    run_op(1, 3'b010, 32'd100, 32'd23, 32'd123, 1'b0, "mid_req1");

    // Randomized run against a transaction-level model
    do_reset();
    m_busy = 1'b0; m_age = 1'b0; m_id = 1'b0; m_last = 1'b1;
    m_ctl = '0; m_a = '0; m_b = '0; m_res = '0; m_zero = 1'b0;
    taken[0] = 1'b0; taken[1] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_i);
      for (int r = 0; r < 2; r++) begin
        if (taken[r]) rv[r] = 1'b0;
        taken[r] = 1'b0;
        if (!rv[r]) begin
          if ($urandom_range(0, 1) == 1) begin
            rv[r] = 1'b1;
            rc[r] = 3'($urandom_range(0, 7));
            ra[r] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
            rb[r] = ($urandom_range(0, 3) == 0) ? ra[r] : $urandom;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          rv[r] = 1'b0;
        end
        rr[r] = ($urandom_range(0, 3) != 0);
      end
      #1;
      if (!m_busy) begin
        w = -1;
        if (rv[0] && rv[1]) begin
`ifdef ALU_ARB_RR_EN
          w = m_last ? 0 : 1;
`else
          w = 0;
`endif
        end else if (rv[0]) w = 0;
        else if (rv[1]) w = 1;
        chk("rnd_ready0", 32'(req0_ready_o), 32'(w == 0));
        chk("rnd_ready1", 32'(req1_ready_o), 32'(w == 1));
        chk("rnd_idle_rspv", 32'({rsp1_valid_o, rsp0_valid_o}), 32'd0);
        if (w >= 0) begin
          m_busy = 1'b1; m_age = 1'b0; m_id = w[0];
          m_ctl = rc[w]; m_a = ra[w]; m_b = rb[w];
          rz = alu_f(m_ctl, m_a, m_b);
          m_zero = rz[32]; m_res = rz[31:0];
          taken[w] = 1'b1;
        end
      end else if (!m_age) begin
        chk("rnd_exec_ready", 32'({req1_ready_o, req0_ready_o}), 32'd0);
        chk("rnd_exec_rspv", 32'({rsp1_valid_o, rsp0_valid_o}), 32'd0);
        chk("rnd_exec_ctl", 32'(alu_ctl_o), 32'(m_ctl));
        chk("rnd_exec_a", alu_a_o, m_a);
        chk("rnd_exec_b", alu_b_o, m_b);
        m_age = 1'b1;
      end else begin
        chk("rnd_resp_ready", 32'({req1_ready_o, req0_ready_o}), 32'd0);
        chk("rnd_rsp0_valid", 32'(rsp0_valid_o), 32'(m_id == 1'b0));
        chk("rnd_rsp1_valid", 32'(rsp1_valid_o), 32'(m_id == 1'b1));
        chk("rnd_result", rsp_result_o, m_res);
        chk("rnd_zero", 32'(rsp_zero_o), 32'(m_zero));
        if (rr[m_id]) begin
          m_busy = 1'b0;
          m_last = m_id;
        end
      end
    end
    rv[0] = 1'b0; rv[1] = 1'b0;
    repeat (3) @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester arbiter and sequencer for the shared 32-bit combinational ALU. It accepts operation requests from two clients (e.g. the EX-stage and a branch/address helper) over valid/ready handshakes and grants one per transaction. It registers the operands, drives the ALU control and operand ports for one cycle, captures the result and Zero flag, and returns them on the granted requester's response channel. It sits between the requesters and the single ALU instance; the ALU itself is unchanged.

## Interface
- DATA_W, 32, operand/result width; must match the ALU.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_ctl / req1_ctl  in  3  ALU control code: 000 and, 001 or, 010 add, 110 sub, 111 slt.
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands.
- rsp0_valid / rsp1_valid  out  1  result available.
- rsp0_ready / rsp1_ready  in  1  requester takes result.
- rsp_result  out  DATA_W  captured ALU result; shared by both response channels.
- rsp_zero  out  1  captured ALU Zero flag.
- alu_ctl  out  3  to ALU control input.
- alu_a, alu_b  out  DATA_W  to ALU operands.
- alu_out  in  DATA_W  from ALU result.
- alu_zero  in  1  from ALU Zero flag.

## Operation
- FSM states: IDLE, EXEC, RESP. Exactly one transaction is in flight.
- IDLE:
  - The grant is computed combinationally from the valid lines.
  - reqN_ready = (state==IDLE) & grant==N. At most one ready is high.
  - On handshake, ctl/a/b are registered into alu_ctl/alu_a/alu_b, the owner ID is stored, and the FSM goes to EXEC.
  - With no valid request, the FSM stays in IDLE.
- EXEC: the registered ALU inputs are stable. At the clock edge, alu_out and alu_zero are captured into rsp_result and rsp_zero, and the FSM goes to RESP.
- RESP:
  - rspN_valid is high for the owner only.
  - It holds, with rsp_result and rsp_zero stable, until rspN_ready is high.
  - On that edge the FSM returns to IDLE and the last-grant pointer is set to the owner.
- Opcodes are not filtered. Undefined codes pass through, and the ALU yields result 0, zero=1.
- Requesters hold valid and payload stable until ready. Dropping valid before ready is permitted; the request is simply not taken.
- The ALU drive registers hold their last values outside EXEC. They change only on a request handshake.

## Timing
- Reset values: state=IDLE, last-grant pointer=1 (so requester 0 wins the first tie), alu_ctl=0, alu_a=0, alu_b=0, rsp_result=0, rsp_zero=0, all rspN_valid=0.
- Latency: handshake at edge k gives the result captured at edge k+1 and rspN_valid high from edge k+1 onward (visible in cycle k+1..k+2).
- Throughput: minimum 3 cycles per operation (IDLE, EXEC, RESP with rsp_ready already high).
- A new request can be accepted in the cycle after the response handshake.
- Simultaneous valid in IDLE is resolved by the arbitration policy (see Configuration).
- A single valid requester is always granted regardless of policy.
- Stalled response (rspN_ready low): the FSM stays in RESP indefinitely. The other requester sees ready=0 throughout.
- Reset asserted mid-transaction: the transaction is discarded immediately, with no response issued. All outputs go to their reset values asynchronously.

## Configuration
- ALU_ARB_RR_EN defined: round-robin arbitration.
  - On a tie, the requester that is not the last-grant pointer wins.
  - The pointer updates on each response handshake.
- ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins a tie.
  - The pointer register is not implemented.

## Test plan
- Single add: req0 ctl=010, a=5, b=7 after reset.
  - req0_ready is high in IDLE, and alu_ctl=010, alu_a=5, alu_b=7 in EXEC.
  - rsp0_valid is high with rsp_result=12, rsp_zero=0, and rsp1_valid stays 0.
- Sub to zero: req1 ctl=110, a=b=0x1234 gives rsp1 result=0, zero=1.
  - slt: ctl=111, a=3, b=9 gives result=1, zero=0.
- Tie: both valid continuously for 4 transactions, with rsp_ready held high.
  - With ALU_ARB_RR_EN the grants are 0,1,0,1.
  - Without it the grants are 0,0,0,0, and req1 is never ready.
- Backpressure: rsp0_ready held low for 5 cycles.
  - rsp0_valid and rsp_result stay stable, and req1_ready stays 0 despite req1_valid.
  - Completion follows in the cycle after rsp0_ready rises.
- Reset mid-op: assert rst_n=0 during EXEC.
  - All outputs are at their reset values with no response.
  - After release, a pending req1 is granted and completes correctly.
- Undefined ctl=011, a=0xFFFFFFFF, b=1 gives rsp_result=0, rsp_zero=1.
